// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station (oldest-ready issue, CDB wakeup; optional RS_WAKEUP_BYPASS_EN)
module alu_rs #(
  parameter int RS_ENTRY     = 4,
  parameter int WORD_SIZE_P  = 16,
  parameter int WIDTH_OP     = 4,
  parameter int ROB_ENTRY    = 16,
  parameter int NUM_PHYS_REG = 32
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            flush_i,
  input  logic                            disp_v_i,
  output logic                            disp_ready_o,
  input  logic [WIDTH_OP-1:0]             disp_op_i,
  input  logic                            disp_src1_rdy_i,
  input  logic                            disp_src2_rdy_i,
  input  logic [$clog2(NUM_PHYS_REG)-1:0] disp_src1_tag_i,
  input  logic [$clog2(NUM_PHYS_REG)-1:0] disp_src2_tag_i,
  input  logic [WORD_SIZE_P-1:0]          disp_src1_val_i,
  input  logic [WORD_SIZE_P-1:0]          disp_src2_val_i,
  input  logic [$clog2(ROB_ENTRY)-1:0]    disp_rob_dest_i,
  input  logic [$clog2(NUM_PHYS_REG)-1:0] disp_reg_dest_i,
  input  logic                            cdb_v_i,
  input  logic [$clog2(NUM_PHYS_REG)-1:0] cdb_dest_i,
  input  logic [WORD_SIZE_P-1:0]          cdb_result_i,
  output logic                            exe_v_o,
  output logic [WIDTH_OP-1:0]             opcode_o,
  output logic [WORD_SIZE_P-1:0]          operand1_o,
  output logic [WORD_SIZE_P-1:0]          operand2_o,
  output logic [$clog2(ROB_ENTRY)-1:0]    rob_dest_o,
  output logic [$clog2(NUM_PHYS_REG)-1:0] reg_dest_o,
  output logic [$clog2(RS_ENTRY):0]       count_o
);
  localparam int IW = $clog2(RS_ENTRY);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(NUM_PHYS_REG);
  localparam int RW = $clog2(ROB_ENTRY);
  localparam logic [CW-1:0] FULL = CW'(RS_ENTRY);
  logic [RS_ENTRY-1:0] valid, s1_rdy, s2_rdy, s1_hit, s2_hit, s1_ok, s2_ok, cand;
  logic [WIDTH_OP-1:0] op [RS_ENTRY];
  logic [TW-1:0] s1_tag [RS_ENTRY];
  logic [TW-1:0] s2_tag [RS_ENTRY];
  logic [WORD_SIZE_P-1:0] s1_val [RS_ENTRY];
  logic [WORD_SIZE_P-1:0] s2_val [RS_ENTRY];
  logic [RW-1:0] rob [RS_ENTRY];
  logic [TW-1:0] rd [RS_ENTRY];
  logic [CW-1:0] age [RS_ENTRY];
  logic [CW-1:0] age_ctr, count;
  logic [IW-1:0] free_idx, sel_idx;
  logic sel_v, accept, d1_hit, d2_hit;
  function automatic logic older(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW-1:0] d;
    d = a - b;
    return d[CW-1];
  endfunction
  assign disp_ready_o = count < FULL;
  assign count_o = count;
  assign accept = disp_v_i && disp_ready_o;
  assign d1_hit = cdb_v_i && !disp_src1_rdy_i && disp_src1_tag_i == cdb_dest_i;
  assign d2_hit = cdb_v_i && !disp_src2_rdy_i && disp_src2_tag_i == cdb_dest_i;
  for (genvar g = 0; g < RS_ENTRY; g++) begin : g_wake
    assign s1_hit[g] = cdb_v_i && !s1_rdy[g] && s1_tag[g] == cdb_dest_i;
    assign s2_hit[g] = cdb_v_i && !s2_rdy[g] && s2_tag[g] == cdb_dest_i;
  end
`ifdef RS_WAKEUP_BYPASS_EN
  assign s1_ok = s1_rdy | s1_hit;
  assign s2_ok = s2_rdy | s2_hit;
`else
  assign s1_ok = s1_rdy;
  assign s2_ok = s2_rdy;
`endif
  assign cand = valid & s1_ok & s2_ok;
  // lowest-index free entry receives the next dispatch
  always_comb begin
    free_idx = '0;
    for (int i = RS_ENTRY - 1; i >= 0; i--) if (!valid[i]) free_idx = IW'(i);
  end
  // pick the oldest ready entry; ages differ by less than RS_ENTRY so modulo compare is safe
  always_comb begin
    sel_v = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < RS_ENTRY; i++)
      if (cand[i] && (!sel_v || older(age[i], age[sel_idx]))) begin
        sel_v = 1'b1;
        sel_idx = IW'(i);
      end
  end
  // control state and issue registers
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      valid <= '0;
      count <= '0;
      age_ctr <= '0;
      exe_v_o <= 1'b0;
      opcode_o <= '0;
      operand1_o <= '0;
      operand2_o <= '0;
      rob_dest_o <= '0;
      reg_dest_o <= '0;
    end else if (flush_i) begin
      valid <= '0;
      count <= '0;
      exe_v_o <= 1'b0;
    end else begin
      exe_v_o <= sel_v;
      if (sel_v) begin
        valid[sel_idx] <= 1'b0;
        opcode_o <= op[sel_idx];
        operand1_o <= s1_rdy[sel_idx] ? s1_val[sel_idx] : cdb_result_i;
        operand2_o <= s2_rdy[sel_idx] ? s2_val[sel_idx] : cdb_result_i;
        rob_dest_o <= rob[sel_idx];
        reg_dest_o <= rd[sel_idx];
      end
      if (accept) begin
        valid[free_idx] <= 1'b1;
        age_ctr <= age_ctr + 1'b1;
      end
      count <= count + CW'(accept) - CW'(sel_v);
    end
  // entry payload: CDB capture, then allocation overrides the free slot
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < RS_ENTRY; i++) begin
      if (s1_hit[i]) begin
        s1_rdy[i] <= 1'b1;
        s1_val[i] <= cdb_result_i;
      end
      if (s2_hit[i]) begin
        s2_rdy[i] <= 1'b1;
        s2_val[i] <= cdb_result_i;
      end
    end
    if (accept) begin
      op[free_idx] <= disp_op_i;
      s1_tag[free_idx] <= disp_src1_tag_i;
      s2_tag[free_idx] <= disp_src2_tag_i;
      s1_rdy[free_idx] <= disp_src1_rdy_i | d1_hit;
      s2_rdy[free_idx] <= disp_src2_rdy_i | d2_hit;
      s1_val[free_idx] <= d1_hit ? cdb_result_i : disp_src1_val_i;
      s2_val[free_idx] <= d2_hit ? cdb_result_i : disp_src2_val_i;
      rob[free_idx] <= disp_rob_dest_i;
      rd[free_idx] <= disp_reg_dest_i;
      age[free_idx] <= age_ctr;
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: scoreboard bench for the ALU reservation station
module tb_alu_rs;
  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  rob;
    logic [4:0]  rd;
  } exp_t;
  logic clk_i = 1'b0, reset_i = 1'b0, flush_i = 1'b0, disp_v_i = 1'b0, disp_ready_o;
  logic [3:0] disp_op_i = '0, disp_rob_dest_i = '0, opcode_o, rob_dest_o;
  logic disp_src1_rdy_i = 1'b0, disp_src2_rdy_i = 1'b0, cdb_v_i = 1'b0, exe_v_o;
  logic [4:0] disp_src1_tag_i = '0, disp_src2_tag_i = '0, disp_reg_dest_i = '0, cdb_dest_i = '0, reg_dest_o;
  logic [15:0] disp_src1_val_i = '0, disp_src2_val_i = '0, cdb_result_i = '0, operand1_o, operand2_o;
  logic [2:0] count_o;
  exp_t q[$];
  int checks = 0, errors = 0, issued = 0;

  alu_rs dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .disp_v_i(disp_v_i),
    .disp_ready_o(disp_ready_o), .disp_op_i(disp_op_i),
    .disp_src1_rdy_i(disp_src1_rdy_i), .disp_src2_rdy_i(disp_src2_rdy_i),
    .disp_src1_tag_i(disp_src1_tag_i), .disp_src2_tag_i(disp_src2_tag_i),
    .disp_src1_val_i(disp_src1_val_i), .disp_src2_val_i(disp_src2_val_i),
    .disp_rob_dest_i(disp_rob_dest_i), .disp_reg_dest_i(disp_reg_dest_i),
    .cdb_v_i(cdb_v_i), .cdb_dest_i(cdb_dest_i), .cdb_result_i(cdb_result_i),
    .exe_v_o(exe_v_o), .opcode_o(opcode_o), .operand1_o(operand1_o), .operand2_o(operand2_o),
    .rob_dest_o(rob_dest_o), .reg_dest_o(reg_dest_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // scoreboard: every issue must match the next expected op in order
  always @(negedge clk_i) begin
    exp_t got, e;
    if (reset_i && exe_v_o) begin
      got = {opcode_o, operand1_o, operand2_o, rob_dest_o, reg_dest_o};
      issued++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got %h, required no issue", got);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL issue_data: got %h, required %h", got, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic disp(input logic [3:0] op, input logic r1, input logic [4:0] t1, input logic [15:0] v1,
                      input logic r2, input logic [4:0] t2, input logic [15:0] v2,
                      input logic [3:0] rob, input logic [4:0] rd);
    disp_v_i = 1'b1; disp_op_i = op;
    disp_src1_rdy_i = r1; disp_src1_tag_i = t1; disp_src1_val_i = v1;
    disp_src2_rdy_i = r2; disp_src2_tag_i = t2; disp_src2_val_i = v2;
    disp_rob_dest_i = rob; disp_reg_dest_i = rd;
    tick();
    disp_v_i = 1'b0;
  endtask

  task automatic cdb(input logic [4:0] t, input logic [15:0] v);
    cdb_v_i = 1'b1; cdb_dest_i = t; cdb_result_i = v;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({exe_v_o, opcode_o, operand1_o, operand2_o, rob_dest_o, reg_dest_o, count_o, disp_ready_o} !== {49'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: exe=%b op1=%h op2=%h cnt=%0d rdy=%b, required 0/0/0/0/1", exe_v_o, operand1_o, operand2_o, count_o, disp_ready_o);
    end
    tick(); tick();
    reset_i = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    q.push_back({4'd0, 16'd5, 16'd3, 4'd2, 5'd7});
    disp(4'd0, 1'b1, 5'd0, 16'd5, 1'b1, 5'd0, 16'd3, 4'd2, 5'd7);
    checks++;
    if (exe_v_o !== 1'b0 || count_o !== 3'd1) begin errors++; $display("FAIL basic_accept: exe=%b cnt=%0d, required 0/1", exe_v_o, count_o); end
    tick();
    checks++;
    if (exe_v_o !== 1'b1 || operand1_o !== 16'd5 || operand2_o !== 16'd3 || rob_dest_o !== 4'd2 || reg_dest_o !== 5'd7) begin
      errors++; $display("FAIL basic_issue: exe=%b op1=%h op2=%h rob=%0d reg=%0d, required 1/5/3/2/7", exe_v_o, operand1_o, operand2_o, rob_dest_o, reg_dest_o);
    end
    tick();
    checks++;
    if (exe_v_o !== 1'b0 || operand1_o !== 16'd5 || count_o !== 3'd0) begin errors++; $display("FAIL basic_hold: exe=%b op1=%h cnt=%0d, required 0/5/0", exe_v_o, operand1_o, count_o); end
  endtask

  task automatic test_wakeup();
    q.push_back({4'd1, 16'h0010, 16'd1, 4'd3, 5'd8});
    disp(4'd1, 1'b0, 5'd9, 16'd0, 1'b1, 5'd0, 16'd1, 4'd3, 5'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (exe_v_o !== 1'b0) begin errors++; $display("FAIL wake_idle%0d: exe=%b, required 0", i, exe_v_o); end
    end
    cdb(5'd9, 16'h0010);
    tick();
    cdb_v_i = 1'b0;
    checks++;
    if (exe_v_o !== 1'b0) begin errors++; $display("FAIL wake_edge: exe=%b, required 0", exe_v_o); end
    tick();
    checks++;
    if (exe_v_o !== 1'b1 || operand1_o !== 16'h0010 || operand2_o !== 16'd1) begin
      errors++; $display("FAIL wake_issue: exe=%b op1=%h op2=%h, required 1/0010/0001", exe_v_o, operand1_o, operand2_o);
    end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      q.push_back({4'd0, 16'h0444, 16'(i), 4'(10 + i), 5'(12 + i)});
      disp(4'd0, 1'b0, 5'd4, 16'd0, 1'b1, 5'd0, 16'(i), 4'(10 + i), 5'(12 + i));
    end
    checks++;
    if (count_o !== 3'd4 || disp_ready_o !== 1'b0) begin errors++; $display("FAIL full_state: cnt=%0d rdy=%b, required 4/0", count_o, disp_ready_o); end
    disp(4'd5, 1'b1, 5'd0, 16'h7777, 1'b1, 5'd0, 16'h7777, 4'd14, 5'd1);
    checks++;
    if (count_o !== 3'd4 || exe_v_o !== 1'b0) begin errors++; $display("FAIL full_ignore: cnt=%0d exe=%b, required 4/0", count_o, exe_v_o); end
    cdb(5'd4, 16'h0444);
    tick();
    cdb_v_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (count_o !== 3'(4 - k) || exe_v_o !== 1'b1) begin errors++; $display("FAIL full_drain%0d: cnt=%0d exe=%b, required %0d/1", k, count_o, exe_v_o, 4 - k); end
    end
    tick();
    checks++;
    if (count_o !== 3'd0 || exe_v_o !== 1'b0) begin errors++; $display("FAIL full_empty: cnt=%0d exe=%b, required 0/0", count_o, exe_v_o); end
  endtask

  task automatic test_age();
    int base = issued;
    q.push_back({4'd2, 16'h0013, 16'd1, 4'd1, 5'd1});
    q.push_back({4'd2, 16'h0014, 16'd2, 4'd2, 5'd2});
    q.push_back({4'd2, 16'h0014, 16'd3, 4'd3, 5'd3});
    disp(4'd2, 1'b0, 5'd13, 16'd0, 1'b1, 5'd0, 16'd1, 4'd1, 5'd1);
    disp(4'd2, 1'b0, 5'd14, 16'd0, 1'b1, 5'd0, 16'd2, 4'd2, 5'd2);
    cdb(5'd13, 16'h0013);
    tick();
    cdb_v_i = 1'b0;
    tick();
    checks++;
    if (count_o !== 3'd1) begin errors++; $display("FAIL age_first: cnt=%0d, required 1", count_o); end
    disp(4'd2, 1'b0, 5'd14, 16'd0, 1'b1, 5'd0, 16'd3, 4'd3, 5'd3);
    cdb(5'd14, 16'h0014);
    tick();
    cdb_v_i = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (issued - base !== 3 || count_o !== 3'd0) begin errors++; $display("FAIL age_done: issued=%0d cnt=%0d, required 3/0", issued - base, count_o); end
  endtask

  task automatic test_collision();
    q.push_back({4'd3, 16'hABCD, 16'd2, 4'd5, 5'd9});
    cdb(5'd6, 16'hABCD);
    disp(4'd3, 1'b0, 5'd6, 16'd0, 1'b1, 5'd0, 16'd2, 4'd5, 5'd9);
    cdb_v_i = 1'b0;
    checks++;
    if (count_o !== 3'd1) begin errors++; $display("FAIL coll_accept: cnt=%0d, required 1", count_o); end
    tick();
    checks++;
    if (exe_v_o !== 1'b1 || operand1_o !== 16'hABCD || count_o !== 3'd0) begin
      errors++; $display("FAIL coll_issue: exe=%b op1=%h cnt=%0d, required 1/abcd/0", exe_v_o, operand1_o, count_o);
    end
    tick();
  endtask

  task automatic test_flush();
    int base;
    for (int i = 0; i < 3; i++) disp(4'd1, 1'b0, 5'd11, 16'd0, 1'b1, 5'd0, 16'(i), 4'(i), 5'(i));
    checks++;
    if (count_o !== 3'd3) begin errors++; $display("FAIL flush_fill: cnt=%0d, required 3", count_o); end
    base = issued;
    flush_i = 1'b1;
    cdb(5'd11, 16'h1111);
    disp(4'd4, 1'b1, 5'd0, 16'd9, 1'b1, 5'd0, 16'd9, 4'd9, 5'd9);
    flush_i = 1'b0;
    cdb_v_i = 1'b0;
    checks++;
    if (count_o !== 3'd0 || exe_v_o !== 1'b0 || disp_ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_clear: cnt=%0d exe=%b rdy=%b, required 0/0/1", count_o, exe_v_o, disp_ready_o);
    end
    repeat (5) tick();
    checks++;
    if (issued !== base || count_o !== 3'd0) begin errors++; $display("FAIL flush_quiet: issues=%0d cnt=%0d, required 0/0", issued - base, count_o); end
  endtask

  task automatic test_back_to_back();
    int base = issued;
    for (int i = 0; i < 6; i++) begin
      q.push_back({4'(i), 16'(100 + i), 16'(200 + i), 4'(i), 5'(20 + i)});
      disp(4'(i), 1'b1, 5'd0, 16'(100 + i), 1'b1, 5'd0, 16'(200 + i), 4'(i), 5'(20 + i));
    end
    tick(); tick();
    checks++;
    if (issued - base !== 6 || count_o !== 3'd0) begin errors++; $display("FAIL b2b_done: issued=%0d cnt=%0d, required 6/0", issued - base, count_o); end
  endtask

  task automatic test_reset_mid();
    q.push_back({4'd0, 16'h0021, 16'h0022, 4'd6, 5'd10});
    disp(4'd0, 1'b1, 5'd0, 16'h0021, 1'b1, 5'd0, 16'h0022, 4'd6, 5'd10);
    disp(4'd0, 1'b0, 5'd17, 16'd0, 1'b1, 5'd0, 16'd0, 4'd7, 5'd11);
    checks++;
    if (exe_v_o !== 1'b1 || count_o !== 3'd1) begin errors++; $display("FAIL rst_pre: exe=%b cnt=%0d, required 1/1", exe_v_o, count_o); end
    @(negedge clk_i);
    #2;
    reset_i = 1'b0;
    #1;
    checks++;
    if (exe_v_o !== 1'b0 || count_o !== 3'd0 || operand1_o !== 16'd0 || disp_ready_o !== 1'b1) begin
      errors++; $display("FAIL rst_async: exe=%b cnt=%0d op1=%h rdy=%b, required 0/0/0/1", exe_v_o, count_o, operand1_o, disp_ready_o);
    end
    tick();
    reset_i = 1'b1;
    repeat (3) tick();
    checks++;
    if (exe_v_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL rst_after: exe=%b cnt=%0d, required 0/0", exe_v_o, count_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_full();
    test_age();
    test_collision();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (q.size() !== 0) begin errors++; $display("FAIL sb_empty: %0d pending, required 0", q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
